lo_sweep_ctrl: RTL and testbench
================================

LO_SWEEP_CTRL -- requirements
Module: lo_sweep_ctrl

Interface
REQ-001 Parameter SYNC_STAGES, 2, synchroniser depth for the pin-driven inputs start and ext_req (min 2).
REQ-002 Parameter DWELL_BASE_LOG2, 4, base log2 of dwell length in clk cycles.
REQ-003 clk  input  1  system clock, 10 MHz nominal.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 sweep_mode  input  1  1 = sweep sequencer, 0 = manual setting.
REQ-006 manual_setting  input  3  LO divide code driven in manual mode.
REQ-007 start  input  1  asynchronous pin; a synchronised rising edge launches a sweep.
REQ-008 ext_req  input  1  asynchronous pin; 1 requests the external LO.
REQ-009 sweep_first  input  3  first divide code of the sweep.
REQ-010 sweep_last  input  3  last divide code of the sweep.
REQ-011 dwell_sel  input  2  dwell = 2^(DWELL_BASE_LOG2 + 2*dwell_sel) cycles (16/64/256/1024 at default).
REQ-012 int_lo_settings  output  3  registered divide code for the downstream LO generator.
REQ-013 ext_lo_en  output  1  registered external-LO select for the downstream LO generator.
REQ-014 busy  output  1  high while the FSM is in SWEEP.
REQ-015 step_strobe  output  1  one-cycle pulse in each cycle int_lo_settings changes during a sweep.
REQ-016 sweep_done  output  1  one-cycle pulse when a sweep completes normally.

Function
REQ-017 start and ext_req SHALL each pass through a SYNC_STAGES flop synchroniser; the start edge is detected on the synchronised signal.
REQ-018 ext_lo_en SHALL equal the synchronised ext_req, registered once (total latency SYNC_STAGES+1 cycles).
REQ-019 FSM states: IDLE, SWEEP, DONE.
REQ-020 IDLE: int_lo_settings <= manual_setting every cycle; start edge with sweep_mode=1 -> SWEEP; start edge with sweep_mode=0 is ignored.
REQ-021 On entry to SWEEP, sweep_first, sweep_last and dwell_sel SHALL be latched; int_lo_settings <= sweep_first, busy=1, dwell counter cleared; no step_strobe on entry.
REQ-022 Direction: ascending if first<last, descending if first>last, single code if equal.
REQ-023 When the dwell counter reaches dwell-1 and the code is not last: code +/-1, step_strobe=1, counter cleared.
REQ-024 When the dwell counter reaches dwell-1 and the code equals last: -> DONE (non-loop build, see REQ-031).
REQ-025 DONE lasts one cycle with sweep_done=1 and busy=0, then IDLE; int_lo_settings holds the last code until IDLE reloads manual_setting.
REQ-026 While ext_lo_en=1 in SWEEP, the dwell counter and code SHALL freeze and resume unchanged when it drops.
REQ-027 sweep_mode=0 in SWEEP SHALL abort to IDLE next cycle with no sweep_done pulse.
REQ-028 A start edge in SWEEP or DONE SHALL be ignored.
REQ-029 Codes are unsigned 3 bits and never wrap past 0 or 7; the dwell counter is 10 bits.

Reset
REQ-030 With rst_n low: state=IDLE, int_lo_settings=0, ext_lo_en=0, busy=0, step_strobe=0, sweep_done=0, synchronisers and counter cleared; mid-sweep reset aborts at once with no pulse.

Configuration
REQ-031 With LO_SWEEP_LOOP_EN defined, reaching last after its dwell SHALL reload first with step_strobe=1 and stay in SWEEP until aborted; sweep_done never pulses. Without it, REQ-024/REQ-025 apply.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, the 3-bit divide-code width and the dwell-table constants.
REQ-033 Sub-module lo_sync (SYNC_STAGES-deep single-bit synchroniser), instantiated twice.

Verification
REQ-034 Manual: sweep_mode=0, manual_setting=5 -> int_lo_settings=5 within 1 cycle, busy=0.
REQ-035 Ascending: first=2, last=4, dwell_sel=0 -> codes 2,3,4 held 16 cycles each, 2 step_strobes, sweep_done 16 cycles after the code-4 load, then back to manual.
REQ-036 Descending/equal: first=6, last=3 -> 6,5,4,3; first=last=7 -> one 16-cycle dwell then sweep_done, no step_strobe.
REQ-037 Freeze: ext_req high for 40 cycles mid-dwell -> ext_lo_en=1 after 3 cycles, code and remaining dwell preserved.
REQ-038 Abort/reset: sweep_mode=0 mid-sweep -> IDLE next cycle, no sweep_done; rst_n low mid-sweep -> all outputs 0 asynchronously.
REQ-039 Loop build: first=1, last=2 -> 1,2,1,2... with step_strobe at every change, sweep_done never asserted.

Source files
------------

// File: rtl/lo_sweep_ctrl_pkg.sv
// Shared FSM encoding, divide-code width and dwell-table constants for the LO sweep controller.
package lo_sweep_ctrl_pkg;

    localparam int CODE_W          = 3;
    localparam int DWELL_SEL_W     = 2;
    localparam int DWELL_CNT_W     = 10;
    localparam int DWELL_STEP_LOG2 = 2;   // each dwell_sel increment multiplies dwell by 4

    typedef logic [CODE_W-1:0]      code_t;
    typedef logic [DWELL_CNT_W-1:0] dwell_cnt_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Terminal count of the dwell counter: 2^(base + 2*sel) - 1.
    function automatic dwell_cnt_t dwell_last(input int base_log2,
                                              input logic [DWELL_SEL_W-1:0] sel);
        int shift;
        shift = base_log2 + DWELL_STEP_LOG2 * int'(sel);
        return dwell_cnt_t'((64'd1 << shift) - 64'd1);
    endfunction

endpackage

// File: rtl/lo_sweep_ctrl_sync.sv
// Single-bit multi-flop synchroniser for asynchronous pins, cleared by rst_n.
module lo_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[STAGES-2:0], d};
        end
    end

    assign q = sync_p[STAGES-1];

endmodule

// File: rtl/lo_sweep_ctrl.sv
// LO divide-code sweep sequencer with manual override and external-LO freeze.
// Optional build macro LO_SWEEP_LOOP_EN: sweep wraps from last back to first until aborted.
module lo_sweep_ctrl
    import lo_sweep_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DWELL_BASE_LOG2 = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sweep_mode,
    input  logic [CODE_W-1:0]      manual_setting,
    input  logic                   start,
    input  logic                   ext_req,
    input  logic [CODE_W-1:0]      sweep_first,
    input  logic [CODE_W-1:0]      sweep_last,
    input  logic [DWELL_SEL_W-1:0] dwell_sel,
    output logic [CODE_W-1:0]      int_lo_settings,
    output logic                   ext_lo_en,
    output logic                   busy,
    output logic                   step_strobe,
    output logic                   sweep_done
);

    logic start_s, ext_s, start_dly_q, start_edge;

    lo_sync #(.STAGES(SYNC_STAGES)) u_sync_start (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (start),
        .q     (start_s)
    );

    lo_sync #(.STAGES(SYNC_STAGES)) u_sync_ext (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ext_req),
        .q     (ext_s)
    );

    assign start_edge = start_s & ~start_dly_q;

    state_t                   state_q, state_d;
    code_t                    code_q, code_d;
    code_t                    first_q, first_d, last_q, last_d;
    logic [DWELL_SEL_W-1:0]   sel_q, sel_d;
    dwell_cnt_t               cnt_q, cnt_d;
    logic                     strobe_q, strobe_d;
    logic                     dwell_end, ascending;

    assign dwell_end = (cnt_q == dwell_last(DWELL_BASE_LOG2, sel_q));
    assign ascending = (first_q < last_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            code_q      <= '0;
            first_q     <= '0;
            last_q      <= '0;
            sel_q       <= '0;
            cnt_q       <= '0;
            strobe_q    <= 1'b0;
            start_dly_q <= 1'b0;
            ext_lo_en   <= 1'b0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            first_q     <= first_d;
            last_q      <= last_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            strobe_q    <= strobe_d;
            start_dly_q <= start_s;
            ext_lo_en   <= ext_s;
        end
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        first_d  = first_q;
        last_d   = last_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        strobe_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                code_d = manual_setting;
                if (start_edge && sweep_mode) begin
                    state_d = ST_SWEEP;
                    code_d  = sweep_first;
                    first_d = sweep_first;
                    last_d  = sweep_last;
                    sel_d   = dwell_sel;
                    cnt_d   = '0;
                end
            end
            ST_SWEEP: begin
                // Abort wins over freeze; freeze holds both code and dwell position.
                if (!sweep_mode) begin
                    state_d = ST_IDLE;
                end else if (!ext_lo_en) begin
                    if (!dwell_end) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        cnt_d = '0;
                        if (code_q != last_q) begin
                            code_d   = ascending ? code_q + 1'b1 : code_q - 1'b1;
                            strobe_d = 1'b1;
                        end else begin
`ifdef LO_SWEEP_LOOP_EN
                            code_d   = first_q;
                            strobe_d = 1'b1;
`else
                            state_d  = ST_DONE;
`endif
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign int_lo_settings = code_q;
    assign busy            = (state_q == ST_SWEEP);
    assign sweep_done      = (state_q == ST_DONE);
    assign step_strobe     = strobe_q;

endmodule

// File: tb/tb_lo_sweep_ctrl.sv
// Self-checking bench for lo_sweep_ctrl: directed and randomized sweeps against a trace-based model.
module tb_lo_sweep_ctrl;

    localparam int EXT_LAT    = 3;   // synchroniser depth 2 plus the output register
    localparam int DWELL_BASE = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sweep_mode;
    logic [2:0] manual_setting;
    logic       start;
    logic       ext_req;
    logic [2:0] sweep_first;
    logic [2:0] sweep_last;
    logic [1:0] dwell_sel;
    logic [2:0] int_lo_settings;
    logic       ext_lo_en;
    logic       busy;
    logic       step_strobe;
    logic       sweep_done;

    int checks = 0;
    int errors = 0;

    // Expected per-cycle record: {code[2:0], busy, strobe, done}
    logic [5:0] trace[$];

    lo_sweep_ctrl #(
        .SYNC_STAGES     (2),
        .DWELL_BASE_LOG2 (DWELL_BASE)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sweep_mode      (sweep_mode),
        .manual_setting  (manual_setting),
        .start           (start),
        .ext_req         (ext_req),
        .sweep_first     (sweep_first),
        .sweep_last      (sweep_last),
        .dwell_sel       (dwell_sel),
        .int_lo_settings (int_lo_settings),
        .ext_lo_en       (ext_lo_en),
        .busy            (busy),
        .step_strobe     (step_strobe),
        .sweep_done      (sweep_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({int_lo_settings, ext_lo_en, busy, step_strobe, sweep_done});
    endfunction

    // Code sequence first..last, each code held for one full dwell, then DONE, IDLE, manual reload.
    task automatic build_trace(input logic [2:0] f, input logic [2:0] l,
                               input logic [1:0] sel, input logic [2:0] man);
        int d, c, fi, li, dir;
        trace.delete();
        fi  = int'(f);
        li  = int'(l);
        d   = 1 << (DWELL_BASE + 2 * int'(sel));
        dir = (fi < li) ? 1 : ((fi > li) ? -1 : 0);
        c   = fi;
        forever begin
            for (int k = 0; k < d; k++)
                trace.push_back({3'(c), 1'b1, (k == 0 && c != fi), 1'b0});
            if (c == li) break;
            c += dir;
        end
        trace.push_back({l, 1'b0, 1'b0, 1'b1});
        trace.push_back({l, 3'b000});
        trace.push_back({man, 3'b000});
    endtask

    task automatic launch(input logic [2:0] f, input logic [2:0] l,
                          input logic [1:0] sel, input logic [2:0] man);
        int n;
        sweep_first    = f;
        sweep_last     = l;
        dwell_sel      = sel;
        manual_setting = man;
        sweep_mode     = 1'b1;
        start          = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!busy && n < 10);
        check($sformatf("launch %0d->%0d busy", f, l), 32'(busy), 32'd1);
        start = 1'b0;
    endtask

    // The trace advances each cycle except while frozen (ext_lo_en high in a busy cycle).
    task automatic run_sweep(input logic [2:0] f, input logic [2:0] l, input logic [1:0] sel,
                             input logic [2:0] man, input int fz_at, input int fz_len);
        int idx, s;
        logic rep, ext_e;
        logic [5:0] e;
        build_trace(f, l, sel, man);
        launch(f, l, sel, man);
        sweep_first = 3'($urandom);
        sweep_last  = 3'($urandom);
        dwell_sel   = 2'($urandom);
        idx = 0;
        s   = 0;
        rep = 1'b0;
        while (idx < trace.size()) begin
            e     = trace[idx];
            ext_e = (s - EXT_LAT >= fz_at) && (s - EXT_LAT < fz_at + fz_len);
            check($sformatf("sweep %0d->%0d sel%0d cyc%0d", f, l, sel, s), all_outs(),
                  32'({e[5:3], ext_e, e[2], e[1] & ~rep, e[0]}));
            if (ext_e && e[2]) rep = 1'b1;
            else begin
                idx++;
                rep = 1'b0;
            end
            ext_req = (s >= fz_at) && (s < fz_at + fz_len);
            start   = (s >= 8 && s <= 10);
            s++;
            step();
        end
        ext_req = 1'b0;
        start   = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        logic any;
        rst_n          = 1'b0;
        sweep_mode     = 1'b0;
        manual_setting = 3'd6;
        start          = 1'b0;
        ext_req        = 1'b0;
        sweep_first    = 3'd0;
        sweep_last     = 3'd0;
        dwell_sel      = 2'd0;
        repeat (3) step();
        check("reset outputs", all_outs(), 32'd0);
        rst_n = 1'b1;

        // Manual mode
        manual_setting = 3'd5;
        step();
        check("manual code", 32'(int_lo_settings), 32'd5);
        check("manual busy", 32'(busy), 32'd0);

        // Start edge ignored in manual mode
        start = 1'b1;
        any   = 1'b0;
        repeat (8) begin
            step();
            any |= busy;
        end
        check("start ignored in manual", 32'(any), 32'd0);
        check("manual code after start", 32'(int_lo_settings), 32'd5);
        start = 1'b0;
        repeat (4) step();

`ifdef LO_SWEEP_LOOP_EN
        launch(3'd1, 3'd2, 2'd0, 3'd4);
        for (int s = 0; s < 96; s++) begin
            check($sformatf("loop cyc%0d", s),
                  32'({int_lo_settings, busy, step_strobe, sweep_done}),
                  32'({((s / 16) % 2 == 1) ? 3'd2 : 3'd1, 1'b1, (s % 16 == 0 && s > 0), 1'b0}));
            step();
        end
        sweep_mode = 1'b0;
        step();
        check("loop abort busy/done", 32'({busy, sweep_done}), 32'd0);
        step();
        check("loop abort manual", 32'(int_lo_settings), 32'd4);
`else
        run_sweep(3'd2, 3'd4, 2'd0, 3'd1, 0, 0);
        run_sweep(3'd6, 3'd3, 2'd0, 3'd0, 0, 0);
        run_sweep(3'd7, 3'd7, 2'd0, 3'd2, 0, 0);
        run_sweep(3'd0, 3'd0, 2'd0, 3'd7, 0, 0);
        run_sweep(3'd3, 3'd5, 2'd0, 3'd1, 5, 40);
        run_sweep(3'd1, 3'd0, 2'd1, 3'd3, 70, 25);
        run_sweep(3'd0, 3'd1, 2'd2, 3'd5, 0, 0);
        run_sweep(3'd5, 3'd4, 2'd3, 3'd6, 0, 0);
        for (int r = 0; r < 6; r++) begin
            run_sweep(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      2'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                      int'($urandom_range(0, 30)),
                      (r % 2 == 1) ? int'($urandom_range(1, 50)) : 0);
        end
`endif

        // Abort mid-sweep via sweep_mode
        launch(3'd0, 3'd7, 2'd0, 3'd6);
        repeat (20) step();
        check("abort pre code", 32'(int_lo_settings), 32'd1);
        sweep_mode = 1'b0;
        step();
        check("abort busy/done", 32'({busy, sweep_done}), 32'd0);
        step();
        check("abort manual reload", 32'(int_lo_settings), 32'd6);
        any = 1'b0;
        repeat (20) begin
            step();
            any |= sweep_done | busy;
        end
        check("abort no done pulse", 32'(any), 32'd0);

        // Asynchronous reset mid-sweep with external LO selected
        launch(3'd0, 3'd7, 2'd1, 3'd3);
        repeat (30) step();
        ext_req = 1'b1;
        repeat (5) step();
        check("pre-reset ext_lo_en", 32'(ext_lo_en), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset outputs", all_outs(), 32'd0);
        ext_req = 1'b0;
        repeat (2) step();
        check("held reset outputs", all_outs(), 32'd0);
        rst_n = 1'b1;
        repeat (2) step();
        check("post-reset manual", 32'({int_lo_settings, busy}), 32'({3'd3, 1'b0}));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
